// File: rtl/morse_decoder.sv
// morse_decoder
//   Decodes a single-key Morse input into one of the eight letters A..H.
//   The key is synchronized, timed in ticks of TICK_CYCLES clocks, and each
//   mark is classified as a dot or a dash. Symbols are collected into a
//   left-aligned 4-bit pattern until a long enough space ends the letter.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   morse_in      in   raw key input (1 = mark, 0 = space), asynchronous
//   letter        out  decoded letter code, A=000 .. H=111 (000 on error)
//   letter_valid  out  one-cycle pulse when letter/letter_err update
//   letter_err    out  last decoded sequence matched no letter
//   sym_count     out  symbols captured so far in the current letter (0..4)
//   busy          out  decoder is not idle
module morse_decoder #(
  parameter int TICK_CYCLES    = 6_250_000,
  parameter int DASH_MIN_TICKS = 16,
  parameter int GAP_MIN_TICKS  = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] sym_count,
  output logic       busy
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = $clog2(GAP_MIN_TICKS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DECODE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_sync1, r_sync2, r_s_d;
  logic           w_s, w_rise, w_fall, w_edge_next, w_tick;
  logic [PW-1:0]  r_presc;
  logic [7:0]     r_mark_cnt;
  logic [SW-1:0]  r_space_cnt;
  logic [3:0]     r_pattern;
  logic [3:0]     w_pat_next;
  logic [2:0]     r_sym_len;
  logic           r_ovf;
  logic           w_start, w_append, w_enter_space, w_clr_mark, w_sym_bit;
  logic [2:0]     w_dec_letter;
  logic           w_dec_hit;
  logic [2:0]     r_letter;
  logic           r_letter_valid, r_letter_err;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= morse_in;
      r_sync2 <= r_sync1;
      r_s_d   <= r_sync2;
    end
  end

  assign w_s    = r_sync2;
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  // s is about to change: clearing the prescaler now makes it read 0 in the
  // first cycle of the new level, so a level of N*TICK_CYCLES clocks sees
  // exactly N ticks.
  assign w_edge_next = r_sync1 ^ r_sync2;
  assign w_tick      = (r_presc == PW'(TICK_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                      r_presc <= '0;
    else if (w_edge_next || w_tick) r_presc <= '0;
    else                            r_presc <= r_presc + 1'b1;
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_append      = 1'b0;
    w_enter_space = 1'b0;
    w_clr_mark    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_next = MARK;
          w_start      = 1'b1;
        end
      end
      MARK: begin
        if (w_fall) begin
          w_enter_space = 1'b1;
          if (r_mark_cnt == 8'd0) begin
            // Mark shorter than one tick: treated as noise.
            w_state_next = (r_sym_len != 3'd0) ? SPACE : IDLE;
          end else begin
            w_append     = 1'b1;
            w_state_next = SPACE;
          end
        end
      end
      SPACE: begin
        // A rising key wins over a gap threshold reached in the same cycle.
        if (w_s) begin
          w_state_next = MARK;
          w_clr_mark   = 1'b1;
        end else if (w_tick && (r_space_cnt == SW'(GAP_MIN_TICKS - 1))) begin
          w_state_next = DECODE;
        end
      end
      DECODE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  assign w_sym_bit = (r_mark_cnt >= 8'(DASH_MIN_TICKS));

  // Symbol k (0-based) lands in pattern bit 3-k; appends beyond the fourth
  // symbol match no bit and leave the pattern untouched.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pat
    assign w_pat_next[gi] = (w_append && (r_sym_len == 3'(3 - gi))) ?
                            w_sym_bit : r_pattern[gi];
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_mark_cnt  <= '0;
      r_space_cnt <= '0;
      r_pattern   <= '0;
      r_sym_len   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_start || w_clr_mark)
        r_mark_cnt <= '0;
      else if ((r_state == MARK) && w_tick && (r_mark_cnt != 8'd255))
        r_mark_cnt <= r_mark_cnt + 1'b1;

      if (w_enter_space)
        r_space_cnt <= '0;
      else if ((r_state == SPACE) && w_tick)
        r_space_cnt <= r_space_cnt + 1'b1;

      if (w_start) begin
        r_pattern <= '0;
        r_sym_len <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_pattern <= w_pat_next;
        if (w_append && (r_sym_len == 3'd4)) r_ovf     <= 1'b1;
        else if (w_append)                   r_sym_len <= r_sym_len + 1'b1;
      end
    end
  end

  // Exact (length, pattern) lookup.
  always_comb begin
    w_dec_letter = 3'd0;
    w_dec_hit    = 1'b0;
    case ({r_sym_len, r_pattern})
      {3'd2, 4'b0100}: begin w_dec_letter = 3'd0; w_dec_hit = 1'b1; end
      {3'd4, 4'b1000}: begin w_dec_letter = 3'd1; w_dec_hit = 1'b1; end
      {3'd4, 4'b1010}: begin w_dec_letter = 3'd2; w_dec_hit = 1'b1; end
      {3'd3, 4'b1000}: begin w_dec_letter = 3'd3; w_dec_hit = 1'b1; end
      {3'd1, 4'b0000}: begin w_dec_letter = 3'd4; w_dec_hit = 1'b1; end
      {3'd4, 4'b0010}: begin w_dec_letter = 3'd5; w_dec_hit = 1'b1; end
      {3'd3, 4'b1100}: begin w_dec_letter = 3'd6; w_dec_hit = 1'b1; end
      {3'd4, 4'b0000}: begin w_dec_letter = 3'd7; w_dec_hit = 1'b1; end
      default: ;
    endcase
    if (r_ovf) begin
      w_dec_letter = 3'd0;
      w_dec_hit    = 1'b0;
    end
  end

  // Results are captured during DECODE, so they and the valid pulse appear
  // in the cycle after DECODE and hold until the next letter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_letter       <= '0;
      r_letter_err   <= 1'b0;
      r_letter_valid <= 1'b0;
    end else begin
      r_letter_valid <= (r_state == DECODE);
      if (r_state == DECODE) begin
        r_letter     <= w_dec_letter;
        r_letter_err <= ~w_dec_hit;
      end
    end
  end

  assign letter       = r_letter;
  assign letter_err   = r_letter_err;
  assign letter_valid = r_letter_valid;
  assign sym_count    = r_sym_len;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder
//   Drives key timings (in clocks) into morse_decoder with small timing
//   parameters and checks decoded letters, error flag, symbol count, busy
//   and the number of letter_valid pulses against expectations derived from
//   Morse timing rules and a dot/dash code table.
module tb_morse_decoder;

  localparam int TICK = 4;
  localparam int DASH = 2;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter;
  logic [2:0] sym_count;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  morse_decoder #(
    .TICK_CYCLES(TICK),
    .DASH_MIN_TICKS(DASH),
    .GAP_MIN_TICKS(GAP)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .morse_in(morse_in),
    .letter(letter),
    .letter_valid(letter_valid),
    .letter_err(letter_err),
    .sym_count(sym_count),
    .busy(busy)
  );

  // Count every cycle in which letter_valid is high.
  always @(negedge clk) begin
    if (letter_valid) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    int n;
    int durs[12];   // alternating high/low lengths in clocks, starting high
    int pulses;
    int let_code;
    int err;
    int cnt;
  } vec_t;

  vec_t  vecs[14];
  string codes[8];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    morse_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Letter from a dot/dash string: code index on a match, error otherwise.
  task automatic model(input string seq, output int l, output int e, output int c);
    l = 0;
    e = 1;
    c = (seq.len() > 4) ? 4 : seq.len();
    if (seq.len() <= 4)
      for (int k = 0; k < 8; k++)
        if (seq == codes[k]) begin
          l = k;
          e = 0;
        end
  endtask

  initial begin
    int    p0;
    int    nsym, hi, lo, el, ee, ec;
    string seq;

    codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    vecs[0]  = '{4,  '{4,4,12,16,0,0,0,0,0,0,0,0},        1, 0, 0, 2}; // A
    vecs[1]  = '{8,  '{12,4,4,4,12,4,4,16,0,0,0,0},       1, 2, 0, 4}; // C
    vecs[2]  = '{2,  '{12,16,0,0,0,0,0,0,0,0,0,0},        1, 0, 1, 1}; // lone dash
    vecs[3]  = '{10, '{4,4,4,4,4,4,4,4,4,16,0,0},         1, 0, 1, 4}; // five dots
    vecs[4]  = '{8,  '{12,4,4,4,4,4,4,16,0,0,0,0},        1, 1, 0, 4}; // B
    vecs[5]  = '{6,  '{12,4,4,4,4,16,0,0,0,0,0,0},        1, 3, 0, 3}; // D
    vecs[6]  = '{8,  '{4,4,4,4,12,4,4,16,0,0,0,0},        1, 5, 0, 4}; // F
    vecs[7]  = '{6,  '{12,4,12,4,4,16,0,0,0,0,0,0},       1, 6, 0, 3}; // G
    vecs[8]  = '{8,  '{4,4,4,4,4,4,4,16,0,0,0,0},         1, 7, 0, 4}; // H
    vecs[9]  = '{2,  '{7,16,0,0,0,0,0,0,0,0,0,0},         1, 4, 0, 1}; // longest dot
    vecs[10] = '{4,  '{4,11,8,16,0,0,0,0,0,0,0,0},        1, 0, 0, 2}; // shortest dash, longest intra gap
    vecs[11] = '{4,  '{4,12,4,16,0,0,0,0,0,0,0,0},        2, 4, 0, 1}; // shortest letter gap: E E
    vecs[12] = '{6,  '{4,4,2,16,0,0,0,0,0,0,0,0},         1, 4, 0, 1}; // glitch inside E gap
    vecs[13] = '{2,  '{2,16,0,0,0,0,0,0,0,0,0,0},         0, 4, 0, 0}; // lone glitch, outputs hold

    // Reset state.
    rst = 1'b1;
    hold(1'b0, 3);
    check("reset letter", int'(letter), 0);
    check("reset letter_valid", int'(letter_valid), 0);
    check("reset letter_err", int'(letter_err), 0);
    check("reset sym_count", int'(sym_count), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    hold(1'b0, 3);

    // Directed table.
    for (int v = 0; v < 14; v++) begin
      p0 = pulse_cnt;
      for (int k = 0; k < vecs[v].n; k++)
        hold((k % 2) == 0, vecs[v].durs[k]);
      hold(1'b0, 4);
      check($sformatf("vec%0d pulses", v), pulse_cnt - p0, vecs[v].pulses);
      check($sformatf("vec%0d letter", v), int'(letter), vecs[v].let_code);
      check($sformatf("vec%0d letter_err", v), int'(letter_err), vecs[v].err);
      check($sformatf("vec%0d sym_count", v), int'(sym_count), vecs[v].cnt);
    end

    // Key held far beyond the mark counter range still reads as a dash.
    p0 = pulse_cnt;
    hold(1'b1, 1030);
    check("long mark busy", int'(busy), 1);
    hold(1'b0, 20);
    check("long mark pulses", pulse_cnt - p0, 1);
    check("long mark letter_err", int'(letter_err), 1);
    check("long mark letter", int'(letter), 0);
    check("long mark sym_count", int'(sym_count), 1);
    check("long mark idle busy", int'(busy), 0);

    // Reset in the middle of a B discards it; a following E decodes.
    p0 = pulse_cnt;
    hold(1'b1, 12);
    hold(1'b0, 4);
    hold(1'b1, 3);
    check("mid-B busy", int'(busy), 1);
    check("mid-B sym_count", int'(sym_count), 1);
    rst = 1'b1;
    hold(1'b1, 2);
    check("mid-B reset sym_count", int'(sym_count), 0);
    check("mid-B reset busy", int'(busy), 0);
    check("mid-B reset letter_err", int'(letter_err), 0);
    rst = 1'b0;
    hold(1'b0, 20);
    check("mid-B no pulse", pulse_cnt - p0, 0);
    p0 = pulse_cnt;
    hold(1'b1, 4);
    hold(1'b0, 20);
    check("post-reset E pulses", pulse_cnt - p0, 1);
    check("post-reset E letter", int'(letter), 4);
    check("post-reset E letter_err", int'(letter_err), 0);

    // Random letters against the timing rules and code table.
    for (int r = 0; r < 40; r++) begin
      p0   = pulse_cnt;
      seq  = "";
      nsym = $urandom_range(1, 5);
      for (int k = 0; k < nsym; k++) begin
        hi  = $urandom_range(4, 20);
        seq = {seq, ((hi / TICK) >= DASH) ? "-" : "."};
        hold(1'b1, hi);
        lo = (k == nsym - 1) ? $urandom_range(GAP * TICK + 4, GAP * TICK + 12)
                             : $urandom_range(TICK, GAP * TICK - 1);
        hold(1'b0, lo);
      end
      hold(1'b0, 2);
      model(seq, el, ee, ec);
      check($sformatf("rnd%0d %s pulses", r, seq), pulse_cnt - p0, 1);
      check($sformatf("rnd%0d %s letter", r, seq), int'(letter), el);
      check($sformatf("rnd%0d %s letter_err", r, seq), int'(letter_err), ee);
      check($sformatf("rnd%0d %s sym_count", r, seq), int'(sym_count), ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
